xcorr_peak_scheduler: RTL
=========================

Name: xcorr_peak_scheduler

Overview:
Controller that sequences readout of the 6-pair cross-correlation datapath. It counts the same sample strobes that enable the correlator and waits out buffer warm-up. Every UPDATE_INTERVAL samples it scans all pairs and lags through an external read mux, finds the argmax lag per pair, and presents the six signed lag offsets to the direction-of-arrival consumer over a valid/ready handshake.

Parameters:
NUM_BITS_XCORR, 31, width of one signed correlation value
NUM_XCORRS, 6, number of microphone pairs
MAX_SAMPLES_DELAY, 11, max lag; lags per pair NUM_LAGS = 2*MAX_SAMPLES_DELAY+1 = 23
WARMUP_SAMPLES, 100, strobes needed after enable before correlation values are meaningful
UPDATE_INTERVAL, 100, strobes between scan triggers (>=1)
LAG_W, $clog2(NUM_LAGS)+1 = 6, width of signed lag offset

Ports:
clk  in  1  clock
rst  in  1  reset
enable_i  in  1  arms controller; low = idle and counters cleared
sample_strobe  in  1  one-cycle pulse, same pulse that enables the correlator
pair_sel  out  $clog2(NUM_XCORRS)  registered pair index to external read mux
lag_sel  out  $clog2(NUM_LAGS)  registered lag index to external read mux
xcorr_value  in  NUM_BITS_XCORR signed  mux output xCorr[pair_sel][lag_sel], combinational, same cycle
res_valid  out  1  result pending
res_ready  in  1  consumer accepts
res_lags  out  NUM_XCORRS*LAG_W  packed, pair p at bits [p*LAG_W +: LAG_W], value = argmax lag_sel - MAX_SAMPLES_DELAY
warm  out  1  warm-up complete
busy  out  1  high in SCAN
overrun  out  1  one-cycle pulse: scan aborted or trigger dropped

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All outputs and state reset to 0; FSM resets to IDLE.
- FSM states: IDLE, WARMUP, WAIT, SCAN.
- IDLE -> WARMUP when enable_i=1. enable_i=0 in any state -> IDLE next cycle. Clears sample/interval counters, warm, best registers. Aborts a scan without an overrun pulse.
- WARMUP: counts sample_strobe, saturating. On the strobe that brings the count to WARMUP_SAMPLES: warm<=1, interval counter<=0, -> WAIT.
- WAIT: the interval counter increments on each strobe. On the strobe where the counter equals UPDATE_INTERVAL-1, it wraps to 0 and this is a trigger.
- On a trigger, if res_valid=1 and res_ready=0 that cycle: drop the trigger, pulse overrun, stay in WAIT. Otherwise -> SCAN next cycle, so the first compare sees correlator values updated by that strobe.
- SCAN:
  - Entry cycle: pair_sel=0, lag_sel=0.
  - Each cycle compare signed xcorr_value against best[pair_sel].
  - At lag_sel=0 the value is loaded unconditionally.
  - Otherwise best and best_lag update only on strictly greater, so ties keep the lowest lag.
  - Advance lag_sel; after NUM_LAGS-1, lag_sel wraps to 0 and pair_sel increments.
  - Scan length is exactly NUM_XCORRS*NUM_LAGS = 138 cycles.
  - After the compare at pair 5 / lag 22: the cycle after, res_lags updates, res_valid=1, and the FSM returns to WAIT.
- sample_strobe during SCAN: abort the scan, pulse overrun, discard partial results. res_lags and res_valid keep their old values. Return to WAIT with the strobe counted (interval counter increments).
- pair_sel and lag_sel return to 0 outside SCAN. busy=1 exactly in SCAN cycles.
- Handshake:
  - res_valid stays high and res_lags stays stable until the cycle res_valid&&res_ready.
  - res_valid clears the next cycle unless a new result completes in that same cycle; then res_valid stays 1 with the new data.
  - A pending result survives enable_i=0 until accepted.
- Width rules:
  - Comparison is full-width signed.
  - Lag offset = zero-extended lag_sel minus MAX_SAMPLES_DELAY, in LAG_W-bit two's complement, range -11..+11.
- Counters are sized for the max of WARMUP_SAMPLES and UPDATE_INTERVAL and never wrap in WARMUP.

Test Plan:
1. Reset: rst=1 mid-scan -> next cycle all outputs 0, state IDLE; after release with enable_i=1, warm rises on strobe #100, not before.
2. Peak detection: after warm, mux model returns 1000 at pair p, lag 3+p, else -5. Trigger on strobe 100 of WAIT. -> busy for 138 cycles, then res_valid=1 with lags {-8,-7,-6,-5,-4,-3} for pairs 0..5.
3. Tie and sign: pair 0 all lags = -2^30, except lags 4 and 17 = 7 -> lag -7 (lowest wins); all-equal negative pair -> -11.
4. Backpressure: res_ready=0 across the next trigger -> overrun pulse, res_lags unchanged. res_ready=1 later -> single accept, res_valid falls the next cycle.
5. Abort: sample_strobe injected at SCAN cycle 50 -> overrun pulse, busy falls, res_valid stays 0, the next trigger 100 strobes after the original one scans normally.
6. Disable: enable_i=0 during WAIT with a result pending -> warm=0, state IDLE, res_valid held until res_ready=1; re-enable requires 100 new strobes to warm.

Source files
------------

// File: rtl/xcorr_peak_scheduler.sv
// Purpose: sequences readout of the pair/lag correlation array and reports the argmax lag per pair.
// Latency: each scan takes NUM_XCORRS*NUM_LAGS cycles after a trigger; the result is visible the cycle after the last compare.
// Backpressure: a result is held until res_ready; a trigger that arrives while a result is stalled is dropped and flagged on overrun.
module xcorr_peak_scheduler #(
  parameter int NUM_BITS_XCORR    = 31,
  parameter int NUM_XCORRS        = 6,
  parameter int MAX_SAMPLES_DELAY = 11,
  parameter int WARMUP_SAMPLES    = 100,
  parameter int UPDATE_INTERVAL   = 100,
  localparam int NUM_LAGS = 2*MAX_SAMPLES_DELAY+1,
  localparam int LAG_W    = $clog2(NUM_LAGS)+1,
  localparam int PAIR_W   = $clog2(NUM_XCORRS),
  localparam int LSEL_W   = $clog2(NUM_LAGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable_i,
  input  logic                             sample_strobe,
  output logic [PAIR_W-1:0]                pair_sel,
  output logic [LSEL_W-1:0]                lag_sel,
  input  logic signed [NUM_BITS_XCORR-1:0] xcorr_value,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_XCORRS*LAG_W-1:0]      res_lags,
  output logic                             warm,
  output logic                             busy,
  output logic                             overrun
);

  localparam int CNT_MAX = (WARMUP_SAMPLES > UPDATE_INTERVAL) ? WARMUP_SAMPLES : UPDATE_INTERVAL;
  localparam int CNT_W   = $clog2(CNT_MAX+1);

  typedef enum logic [1:0] {IDLE, WARMUP, WAIT, SCAN} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                 warm_cnt;
  logic [CNT_W-1:0]                 ivl_cnt;
  logic signed [NUM_BITS_XCORR-1:0] best_val;
  logic [LSEL_W-1:0]                best_lag;
  logic [NUM_XCORRS*LAG_W-1:0]      stage;
  logic [NUM_XCORRS*LAG_W-1:0]      final_lags;

  logic warm_done, start, drop, abort, scan_last;
  logic last_lag, last_pair, take;
  logic [LSEL_W-1:0] cur_lag;
  logic [LAG_W-1:0]  cur_off;

  assign last_lag  = (lag_sel == LSEL_W'(NUM_LAGS-1));
  assign last_pair = (pair_sel == PAIR_W'(NUM_XCORRS-1));
  // Lag 0 seeds the running best; afterwards only a strictly larger value wins, so ties keep the lowest lag.
  assign take      = (lag_sel == '0) || (xcorr_value > best_val);
  assign cur_lag   = take ? lag_sel : best_lag;
  assign cur_off   = LAG_W'(cur_lag) - LAG_W'(MAX_SAMPLES_DELAY);
  assign busy      = (state == SCAN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and one-cycle control decode; disable overrides everything and never flags overrun.
  always_comb begin
    state_nxt = state;
    warm_done = 1'b0;
    start     = 1'b0;
    drop      = 1'b0;
    abort     = 1'b0;
    scan_last = 1'b0;
    if (!enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = WARMUP;
        WARMUP: begin
          if (sample_strobe && warm_cnt == CNT_W'(WARMUP_SAMPLES-1)) begin
            warm_done = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (sample_strobe && ivl_cnt == CNT_W'(UPDATE_INTERVAL-1)) begin
            if (res_valid && !res_ready) begin
              drop = 1'b1;
            end else begin
              start     = 1'b1;
              state_nxt = SCAN;
            end
          end
        end
        SCAN: begin
          if (sample_strobe) begin
            abort     = 1'b1;
            state_nxt = WAIT;
          end else if (last_lag && last_pair) begin
            scan_last = 1'b1;
            state_nxt = WAIT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Warm-up and interval counters; a strobe that aborts a scan still counts toward the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      ivl_cnt  <= '0;
      warm     <= 1'b0;
    end else if (!enable_i) begin
      warm_cnt <= '0;
      ivl_cnt  <= '0;
      warm     <= 1'b0;
    end else begin
      if (state == WARMUP && sample_strobe && !warm_done) warm_cnt <= warm_cnt + 1'b1;
      if (warm_done) warm <= 1'b1;
      if (warm_done) begin
        ivl_cnt <= '0;
      end else if ((state == WAIT || state == SCAN) && sample_strobe) begin
        ivl_cnt <= (ivl_cnt == CNT_W'(UPDATE_INTERVAL-1)) ? '0 : ivl_cnt + 1'b1;
      end
    end
  end

  // Read-mux address walk: lags fastest, then pairs; parked at zero outside a scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_sel <= '0;
      lag_sel  <= '0;
    end else if (state == SCAN && state_nxt == SCAN) begin
      if (last_lag) begin
        lag_sel  <= '0;
        pair_sel <= pair_sel + 1'b1;
      end else begin
        lag_sel <= lag_sel + 1'b1;
      end
    end else begin
      pair_sel <= '0;
      lag_sel  <= '0;
    end
  end

  // Running max for the current pair; the finished pair's offset is parked in stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val <= '0;
      best_lag <= '0;
      stage    <= '0;
    end else if (!enable_i) begin
      best_val <= '0;
      best_lag <= '0;
      stage    <= '0;
    end else if (state == SCAN) begin
      if (take) begin
        best_val <= xcorr_value;
        best_lag <= lag_sel;
      end
      if (last_lag) stage[pair_sel*LAG_W +: LAG_W] <= cur_off;
    end
  end

  // Final vector folds in the last pair's offset, which is only known during the last compare.
  always_comb begin
    final_lags = stage;
    final_lags[pair_sel*LAG_W +: LAG_W] = cur_off;
  end

  // Result handshake and overrun pulse; a pending result survives disable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_lags  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop | abort;
      if (scan_last) begin
        res_valid <= 1'b1;
        res_lags  <= final_lags;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
